// File: rtl/mvu_jobctl.sv
// rtl/mvu_jobctl.sv - job sequencer for the MVU input/weight AGU: clear, step, drain, done.
// Optional stall-cycle counter is built when MVU_JOBCTL_PERF_EN is defined.
module mvu_jobctl #(
  parameter int BPREC        = 6,
  parameter int BWBANKA      = 9,
  parameter int BDBANKA      = 15,
  parameter int BCNT         = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [BPREC-1:0]   cfg_iprecision,
  input  logic [BPREC-1:0]   cfg_wprecision,
  input  logic [BDBANKA-1:0] cfg_ibaseaddr,
  input  logic [BWBANKA-1:0] cfg_wbaseaddr,
  input  logic [BCNT-1:0]    cfg_nsteps,
  input  logic               stall,
  output logic               agu_clr,
  output logic               agu_en,
  output logic [BPREC-1:0]   agu_iprecision,
  output logic [BPREC-1:0]   agu_wprecision,
  output logic [BDBANKA-1:0] agu_ibaseaddr,
  output logic [BWBANKA-1:0] agu_wbaseaddr,
  input  logic               agu_shacc_done,
  output logic               busy,
  output logic               done,
  output logic [BCNT-1:0]    acc_count,
  output logic [BCNT-1:0]    perf_stall_cycles
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [BCNT-1:0]   remaining_q, remaining_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [BCNT-1:0]   acc_q, acc_d;
  logic              clr_q, done_q;
  logic              accept;
  logic              counting;
  logic [BPREC-1:0]   iprec_q, wprec_q;
  logic [BDBANKA-1:0] ibase_q;
  logic [BWBANKA-1:0] wbase_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept      = 1'b1;
          remaining_d = cfg_nsteps;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (remaining_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_RUN: begin
        if (!stall) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == BCNT'(1)) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_INIT;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator events count only while the job is stepping or draining.
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    acc_d = acc_q;
    if (accept)                                          acc_d = '0;
    else if (counting && agu_shacc_done && acc_q != '1) acc_d = acc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
      acc_q       <= '0;
      clr_q       <= 1'b1;
      done_q      <= 1'b0;
      iprec_q     <= '0;
      wprec_q     <= '0;
      ibase_q     <= '0;
      wbase_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      acc_q       <= acc_d;
      clr_q       <= (state_d == S_CLEAR);
      done_q      <= (state_d == S_DONE);
      if (accept) begin
        iprec_q <= cfg_iprecision;
        wprec_q <= cfg_wprecision;
        ibase_q <= cfg_ibaseaddr;
        wbase_q <= cfg_wbaseaddr;
      end
    end
  end

`ifdef MVU_JOBCTL_PERF_EN
  logic [BCNT-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                                              perf_q <= '0;
    else if (accept)                                      perf_q <= '0;
    else if (state_q == S_RUN && stall && perf_q != '1)   perf_q <= perf_q + 1'b1;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

  assign ready          = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign agu_en         = (state_q == S_RUN) && !stall;
  assign agu_clr        = clr_q;
  assign done           = done_q;
  assign acc_count      = acc_q;
  assign agu_iprecision = iprec_q;
  assign agu_wprecision = wprec_q;
  assign agu_ibaseaddr  = ibase_q;
  assign agu_wbaseaddr  = wbase_q;

endmodule

// File: tb/tb_mvu_jobctl.sv
// tb/tb_mvu_jobctl.sv - self-checking bench for mvu_jobctl against a cycle-count job model.
module tb_mvu_jobctl;
  localparam int BPREC = 6, BWBANKA = 9, BDBANKA = 15, BCNT = 16, D = 3;

  logic               clk = 1'b0;
  logic               rst, start, stall, shacc;
  logic               ready, agu_clr, agu_en, busy, done;
  logic [BPREC-1:0]   cfg_iprecision, cfg_wprecision, agu_iprecision, agu_wprecision;
  logic [BDBANKA-1:0] cfg_ibaseaddr, agu_ibaseaddr;
  logic [BWBANKA-1:0] cfg_wbaseaddr, agu_wbaseaddr;
  logic [BCNT-1:0]    cfg_nsteps, acc_count, perf_stall_cycles;

  int checks = 0;
  int errors = 0;

  mvu_jobctl #(
    .BPREC(BPREC), .BWBANKA(BWBANKA), .BDBANKA(BDBANKA), .BCNT(BCNT), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .cfg_iprecision(cfg_iprecision), .cfg_wprecision(cfg_wprecision),
    .cfg_ibaseaddr(cfg_ibaseaddr), .cfg_wbaseaddr(cfg_wbaseaddr), .cfg_nsteps(cfg_nsteps),
    .stall(stall), .agu_clr(agu_clr), .agu_en(agu_en),
    .agu_iprecision(agu_iprecision), .agu_wprecision(agu_wprecision),
    .agu_ibaseaddr(agu_ibaseaddr), .agu_wbaseaddr(agu_wbaseaddr),
    .agu_shacc_done(shacc), .busy(busy), .done(done),
    .acc_count(acc_count), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job: start at cycle T, then cycle k = 1,2,... after it. The model knows only the
  // job rules: clear at k=1, steps from k=2 on unstalled cycles, drain D cycles, done, idle.
  task automatic run_job(input int n, input int stall_pct, input logic [31:0] smask,
                         input int shacc_pct, input logic [31:0] amask, input bit restart);
    logic [BPREC-1:0]   ip, wp;
    logic [BDBANKA-1:0] ib;
    logic [BWBANKA-1:0] wb;
    int  steps, done_k, accs, stalls, exp_perf;
    bit  fin, in_run, exp_en;
    ip = BPREC'($urandom);
    wp = BPREC'($urandom);
    ib = BDBANKA'($urandom);
    wb = BWBANKA'($urandom);
    @(posedge clk); #1;
    start = 1'b1; stall = 1'b0; shacc = 1'b0;
    cfg_iprecision = ip; cfg_wprecision = wp; cfg_ibaseaddr = ib; cfg_wbaseaddr = wb;
    cfg_nsteps = BCNT'(n);
    @(negedge clk);
    chk("ready_at_start", 32'(ready), 1);
    chk("en_at_start", 32'(agu_en), 0);
    steps = 0; done_k = 0; accs = 0; stalls = 0; fin = 0;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      @(posedge clk); #1;
      start = restart && (k == 3);
      if (start) begin
        cfg_iprecision = ~ip; cfg_wprecision = ~wp; cfg_ibaseaddr = ~ib; cfg_wbaseaddr = ~wb;
        cfg_nsteps = BCNT'(n + 7);
      end
      in_run = (k >= 2) && (steps < n);
      if (k >= 2 && !in_run && done_k == 0) done_k = k + D;
      stall = ((k >= 2 && k < 34) ? smask[k-2] : 1'b0) || ($urandom_range(99) < stall_pct);
      shacc = ((k >= 2 && k < 34) ? amask[k-2] : 1'b0) || ($urandom_range(99) < shacc_pct);
      exp_en = in_run && !stall;
      @(negedge clk);
      chk("agu_en", 32'(agu_en), 32'(exp_en));
      chk("agu_clr", 32'(agu_clr), 32'(k == 1));
      chk("done", 32'(done), 32'(done_k != 0 && k == done_k));
      chk("busy", 32'(busy), 32'(!(done_k != 0 && k > done_k)));
      chk("agu_iprecision", 32'(agu_iprecision), 32'(ip));
      chk("agu_wprecision", 32'(agu_wprecision), 32'(wp));
      chk("agu_ibaseaddr", 32'(agu_ibaseaddr), 32'(ib));
      chk("agu_wbaseaddr", 32'(agu_wbaseaddr), 32'(wb));
      if (k >= 2 && (done_k == 0 || k < done_k) && shacc) accs++;
      if (in_run && stall) stalls++;
      if (exp_en) steps++;
      if (done_k != 0 && k == done_k + 1) begin
`ifdef MVU_JOBCTL_PERF_EN
        exp_perf = stalls;
`else
        exp_perf = 0;
`endif
        chk("ready_after_done", 32'(ready), 1);
        chk("acc_count", 32'(acc_count), 32'(accs));
        chk("perf_stall_cycles", 32'(perf_stall_cycles), 32'(exp_perf));
        chk("step_total", 32'(steps), 32'(n));
        fin = 1;
      end
    end
    if (!fin) chk("job_timeout", 0, 1);
    start = 1'b0; stall = 1'b0; shacc = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_clr"}, 32'(agu_clr), 1);
    chk({tag, "_en"}, 32'(agu_en), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_acc"}, 32'(acc_count), 0);
    chk({tag, "_perf"}, 32'(perf_stall_cycles), 0);
    chk({tag, "_cfg"}, 32'({agu_iprecision, agu_wprecision} | agu_ibaseaddr | agu_wbaseaddr), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; shacc = 1'b0;
    cfg_iprecision = '0; cfg_wprecision = '0; cfg_ibaseaddr = '0; cfg_wbaseaddr = '0;
    cfg_nsteps = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_job(5, 0, 32'h0, 0, 32'h0, 1'b0);
    run_job(4, 0, 32'h6, 0, 32'h0, 1'b0);
    run_job(0, 0, 32'h0, 0, 32'h0, 1'b0);
    run_job(8, 0, 32'h0, 0, 32'h211, 1'b0);
    repeat (4) begin
      @(posedge clk); #1; shacc = 1'b1;
      @(negedge clk);
      chk("acc_hold_idle", 32'(acc_count), 3);
    end
    shacc = 1'b0;
    run_job(6, 0, 32'h0, 20, 32'h0, 1'b1);

    // Reset two steps into a 10-step job.
    @(posedge clk); #1;
    start = 1'b1; cfg_nsteps = 16'd10;
    cfg_iprecision = 6'h2a; cfg_wprecision = 6'h15; cfg_ibaseaddr = 15'h1234; cfg_wbaseaddr = 9'h0a5;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1; shacc = 1'b1;
      @(negedge clk);
      chk("pre_reset_en", 32'(agu_en), 1);
    end
    @(posedge clk); #1; shacc = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_values("midjob_reset");
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_done_after_reset", 32'(done), 0);
      chk("no_en_after_reset", 32'(agu_en), 0);
    end
    run_job(6, 0, 32'h0, 0, 32'h0, 1'b0);

    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(20, 0), $urandom_range(40, 0), $urandom, 30, 32'h0, 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mvu_jobctl.md
# mvu_jobctl

Job sequencer for the MVU input/weight address-generation path. It accepts one job descriptor per handshake, latches the per-job configuration, and clears the address generator. It then drives its enable for exactly the programmed number of steps, honouring datapath back-pressure, and counts accumulator-done events. After a fixed pipeline drain it signals completion. It sits between the controller's command interface and the input/weight AGU.

## Interface
Parameters:
- `BPREC`, 6, precision field width
- `BWBANKA`, 9, weight memory address width
- `BDBANKA`, 15, data memory address width
- `BCNT`, 16, step-count and accumulator-count width
- `DRAIN_CYCLES`, 3, cycles between last enable and `done` (≥1)

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  job request
- `ready`  out  1  block idle, `start` accepted this cycle
- `cfg_iprecision`  in  BPREC  input precision for the job
- `cfg_wprecision`  in  BPREC  weight precision for the job
- `cfg_ibaseaddr`  in  BDBANKA  input base address
- `cfg_wbaseaddr`  in  BWBANKA  weight base address
- `cfg_nsteps`  in  BCNT  number of AGU steps in the job
- `stall`  in  1  datapath back-pressure; suppresses stepping
- `agu_clr`  out  1  AGU clear
- `agu_en`  out  1  AGU step enable
- `agu_iprecision`, `agu_wprecision`, `agu_ibaseaddr`, `agu_wbaseaddr`  out  as cfg  latched job config
- `agu_shacc_done`  in  1  accumulation-done pulse from the AGU
- `busy`  out  1  job in progress (not IDLE)
- `done`  out  1  one-cycle job-completion pulse
- `acc_count`  out  BCNT  `agu_shacc_done` events in the current or last job
- `perf_stall_cycles`  out  BCNT  stalled RUN cycles (see Configuration)

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: `ready`=1. If `start`=1, the block:
  - latches all `cfg_*` into the `agu_*` registers and loads `remaining`=`cfg_nsteps`;
  - zeroes `acc_count` and `perf_stall_cycles`;
  - moves to CLEAR.
- `start` in any other state is ignored. Latched config is held stable until the next accepted `start`.
- CLEAR, one cycle: `agu_clr`=1. The next state is RUN if `remaining`≠0, otherwise DRAIN.
- RUN: `agu_en` = ~`stall`. Each cycle with `agu_en`=1 decrements `remaining`. A cycle with `agu_en`=1 and `remaining`=1 is the last step, and the next state is DRAIN. `agu_en` is never asserted outside RUN.
- DRAIN: a counter loads `DRAIN_CYCLES`-1 and counts down to 0, then the block moves to DONE. DRAIN lasts exactly `DRAIN_CYCLES` cycles.
- DONE, one cycle: `done`=1, then IDLE.
- `acc_count`:
  - increments on `agu_shacc_done`=1 in RUN or DRAIN;
  - saturates at all-ones;
  - holds its value in IDLE until the next accepted `start`.
- `cfg_nsteps` arithmetic is unsigned BCNT-bit; `cfg_nsteps`=0 is a legal zero-length job.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `agu_clr`=1 (the AGU is held clear during reset), `agu_en`=0, `done`=0, `acc_count`=0, `perf_stall_cycles`=0, all `agu_*` config=0.
- `ready` and `busy` decode state combinationally. `agu_en` = (state==RUN)&~`stall`, combinational in `stall`. `agu_clr` and `done` are registered state decodes.
- For a `start` accepted at cycle T:
  - `agu_clr` is high at T+1;
  - the first possible `agu_en` is at T+2;
  - with no stall and N≥1, `done` is at T+2+N+`DRAIN_CYCLES` and `ready` returns at T+3+N+`DRAIN_CYCLES`.
- With N=0, `done` is at T+2+`DRAIN_CYCLES`.
- Each stalled RUN cycle adds exactly one cycle to completion.
- `rst` mid-job: the next cycle is IDLE with reset values. No `done` is issued and the partial `acc_count` is discarded.
- `agu_shacc_done` coincident with the transition to IDLE (in DONE) is not counted.

## Configuration
- `MVU_JOBCTL_PERF_EN` defined: `perf_stall_cycles` increments each RUN cycle with `stall`=1. It saturates, clears on accepted `start`, and holds in IDLE.
- Not defined: no counter register is built; `perf_stall_cycles` is tied to 0.

## Test plan
- Reset, then `start` with nsteps=5, `stall`=0, DRAIN_CYCLES=3 → `agu_clr` at T+1, `agu_en` high T+2..T+6, `done` at T+10, `ready` at T+11.
- nsteps=4 with `stall` high on the 2nd and 3rd RUN cycles → exactly 4 `agu_en` cycles, `done` at T+11, and `perf_stall_cycles`=2 (0 without the macro).
- nsteps=0 → no `agu_en` ever, `done` at T+5, `acc_count`=0.
- nsteps=8 with `agu_shacc_done` pulsed 3 times during RUN/DRAIN → `acc_count`=3 after `done`, and it holds until the next `start`.
- `start` re-asserted in RUN with different cfg → ignored: `agu_*` config unchanged and step count unchanged.
- `rst` asserted mid-RUN after 2 steps → next cycle `ready`=1, `agu_clr`=1 during reset, no `done`, counts zeroed. A new job then completes normally.
